// File: rtl/bpsk_transmitter_pkg.sv
// Shared parameters, state encodings and the frame check used across the BPSK transmit path.
package bpsk_transmitter_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int PACKET_SIZE     = 32;
  localparam int BAUD_DIV        = 4;
  localparam int SAMPLES_PER_BIT = 8;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // A byte is good when D0..D7 plus parity has even weight and the stop bit is high.
  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return (^{data, par} == 1'b0) && stop;
  endfunction

endpackage

// File: rtl/bpsk_transmitter_uart_deserialize.sv
// UART receiver: 2-FF line synchronizer, 11-bit frame FSM and even-parity/stop check.
//
// state     | meaning
// RX_IDLE   | line idle high, waiting for a low level
// RX_START  | half-bit wait, confirm start bit at its centre
// RX_DATA   | sample D0..D7 mid-bit, LSB first
// RX_PARITY | sample parity bit
// RX_STOP   | sample stop bit, then accept or flag the byte
module uart_deserialize #(
  parameter int BAUD_DIV = bpsk_transmitter_pkg::BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_error
);
  import bpsk_transmitter_pkg::*;

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_DATA   = 4'(UART_FRAME_BITS - 3);

  logic      line_meta;
  logic      line_sync;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          parity_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      line_meta <= line;
      line_sync <= line_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      data_byte   <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!line_sync) begin
            state <= RX_START;
            cnt   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!line_sync) begin
            state   <= RX_DATA;
            cnt     <= BIT_RELOAD;
            bit_idx <= 4'd1;
          end else begin
            state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift_reg <= {line_sync, shift_reg[7:1]};
            cnt       <= BIT_RELOAD;
            if (bit_idx == LAST_DATA) state <= RX_PARITY;
            else bit_idx <= bit_idx + 4'd1;
          end
        end
        RX_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            parity_bit <= line_sync;
            cnt        <= BIT_RELOAD;
            state      <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RX_IDLE;
            if (frame_ok(shift_reg, parity_bit, line_sync)) begin
              data_byte  <= shift_reg;
              byte_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bpsk_transmitter.sv
// BPSK transmitter: packs UART bytes into packets and modulates them onto an fs/4 carrier.
//
// state   | meaning
// TX_IDLE | no packet in flight, signal held at 0
// TX_SEND | shifting packet bits out MSB first, SAMPLES_PER_BIT samples each
module bpsk_transmitter #(
  parameter int DATA_WIDTH      = bpsk_transmitter_pkg::DATA_WIDTH,
  parameter int PACKET_SIZE     = bpsk_transmitter_pkg::PACKET_SIZE,
  parameter int BAUD_DIV        = bpsk_transmitter_pkg::BAUD_DIV,
  parameter int SAMPLES_PER_BIT = bpsk_transmitter_pkg::SAMPLES_PER_BIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         uart_stream,
  output logic signed [DATA_WIDTH-1:0] signal,
  output logic                         tx_active,
  output logic                         frame_error,
  output logic                         overflow
);
  import bpsk_transmitter_pkg::*;

  localparam int BYTES_PER_PKT = PACKET_SIZE / 8;
  localparam int BCW           = $clog2(BYTES_PER_PKT + 1);
  localparam int BIW           = $clog2(PACKET_SIZE);
  localparam int SCW           = $clog2(SAMPLES_PER_BIT);
  localparam logic [BCW-1:0] LAST_BYTE   = BCW'(BYTES_PER_PKT - 1);
  localparam logic [BIW-1:0] FIRST_BIT   = BIW'(PACKET_SIZE - 1);
  localparam logic [SCW-1:0] SAMP_RELOAD = SCW'(SAMPLES_PER_BIT - 1);
  // Symmetric amplitude keeps -AMP one code above the most-negative value.
  localparam logic signed [DATA_WIDTH-1:0] AMP = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_deserialize #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .line        (uart_stream),
    .data_byte   (rx_byte),
    .byte_valid  (rx_valid),
    .frame_error (frame_error)
  );

  logic [PACKET_SIZE-1:0] packet;
  logic [PACKET_SIZE-1:0] packet_next;
  logic [PACKET_SIZE-1:0] pkt_buf;
  logic [BCW-1:0]         byte_cnt;
  logic                   pkt_done;

  always_comb begin
    packet_next = packet;
    packet_next[PACKET_SIZE-1-8*byte_cnt -: 8] = rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet   <= '0;
      pkt_buf  <= '0;
      byte_cnt <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (rx_valid) begin
        if (byte_cnt == LAST_BYTE) begin
          pkt_buf  <= packet_next;
          pkt_done <= 1'b1;
          packet   <= '0;
          byte_cnt <= '0;
        end else begin
          packet   <= packet_next;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  function automatic logic signed [DATA_WIDTH-1:0] carrier(input logic bit_val, input logic [1:0] ph);
    logic signed [DATA_WIDTH-1:0] s;
    s = '0;
    if (ph == 2'd1) s = bit_val ? AMP : -AMP;
    else if (ph == 2'd3) s = bit_val ? -AMP : AMP;
    return s;
  endfunction

  tx_state_t              tx_state;
  logic [PACKET_SIZE-1:0] tx_reg;
  logic [BIW-1:0]         bit_idx;
  logic [SCW-1:0]         samp_cnt;
  logic [1:0]             phase;

  // Phase 0 is always a zero sample, so a bit boundary never needs the next bit's value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_reg    <= '0;
      bit_idx   <= '0;
      samp_cnt  <= '0;
      phase     <= '0;
      signal    <= '0;
      tx_active <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          signal    <= '0;
          tx_active <= 1'b0;
          if (pkt_done) begin
            tx_reg    <= pkt_buf;
            bit_idx   <= FIRST_BIT;
            samp_cnt  <= SAMP_RELOAD;
            phase     <= 2'd0;
            tx_active <= 1'b1;
            tx_state  <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (pkt_done) overflow <= 1'b1;
          if (samp_cnt == '0) begin
            phase    <= 2'd0;
            signal   <= '0;
            samp_cnt <= SAMP_RELOAD;
            if (bit_idx == '0) begin
              tx_state  <= TX_IDLE;
              tx_active <= 1'b0;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            samp_cnt <= samp_cnt - 1'b1;
            phase    <= phase + 2'd1;
            signal   <= carrier(tx_reg[bit_idx], phase + 2'd1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_transmitter.sv
// Self-checking bench for bpsk_transmitter: UART frame driver, sample recorder, packet-level model.
module tb_bpsk_transmitter;

  localparam int DW      = 8;
  localparam int PS      = 32;
  localparam int BD      = 4;
  localparam int SPB     = 8;
  localparam int A       = 127;
  localparam int PKT_CYC = PS * SPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_stream = 1'b1;
  logic signed [DW-1:0] signal;
  logic tx_active;
  logic frame_error;
  logic overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bpsk_transmitter #(
    .DATA_WIDTH(DW), .PACKET_SIZE(PS), .BAUD_DIV(BD), .SAMPLES_PER_BIT(SPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_stream (uart_stream),
    .signal      (signal),
    .tx_active   (tx_active),
    .frame_error (frame_error),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Recorder: samples during tx_active, run lengths, pulse counts.
  logic signed [DW-1:0] samp_q[$];
  int run_len_q[$];
  int cur_run = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int idle_nz = 0;
  int neg_min = 0;
  int rise_cyc = 0;

  always @(negedge clk) begin
    if (tx_active === 1'b1) begin
      if (cur_run == 0) rise_cyc = cyc;
      samp_q.push_back(signal);
      cur_run++;
    end else begin
      if (cur_run != 0) run_len_q.push_back(cur_run);
      cur_run = 0;
      if (signal !== '0) idle_nz++;
    end
    if (frame_error === 1'b1) fe_cnt++;
    if (overflow === 1'b1) ov_cnt++;
    if (signal === 8'sh80) neg_min++;
  end

  function automatic int model_sample(input logic [PS-1:0] pkt, input int k);
    logic b;
    int p;
    b = pkt[PS-1-k/SPB];
    p = k % 4;
    if (p == 1) return b ? A : -A;
    if (p == 3) return b ? -A : A;
    return 0;
  endfunction

  function automatic int stream_errors(input logic [PS-1:0] pkt, input int base);
    int e;
    e = 0;
    for (int k = 0; k < PKT_CYC; k++) begin
      if (base + k >= samp_q.size()) e++;
      else if (int'(samp_q[base+k]) != model_sample(pkt, k)) e++;
    end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      uart_stream = f[i];
      tick(BD);
    end
    uart_stream = 1'b1;
  endtask

  task automatic send_packet(input logic [PS-1:0] p);
    for (int b = 0; b < PS / 8; b++) send_frame(p[PS-1-8*b -: 8], 1'b0, 1'b0);
  endtask

  task automatic wait_runs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (run_len_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++;
    if ({signal, tx_active, frame_error, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got sig=%0d act=%b fe=%b ov=%b want all 0",
               signal, tx_active, frame_error, overflow);
    end
    rst = 1'b0;
    tick(10);
    checks++;
    if (tx_active !== 1'b0 || signal !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got act=%b sig=%0d want 0 0", tx_active, signal);
    end
  endtask

  task automatic test_basic;
    int base, r0, fe0, ov0, end_cyc, e;
    bit ok;
    int exp1[8] = '{0, 127, 0, -127, 0, 127, 0, -127};
    base = samp_q.size(); r0 = run_len_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_packet(32'hA53C00FF);
    end_cyc = cyc;
    wait_runs(r0 + 1, 600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got runs=%0d want %0d", run_len_q.size(), r0 + 1); end
    if (ok) begin
      checks++;
      if (run_len_q[r0] != PKT_CYC) begin
        failures++; $display("FAIL basic_run_len got %0d want %0d", run_len_q[r0], PKT_CYC);
      end
      e = 0;
      for (int k = 0; k < 8; k++) begin
        if (int'(samp_q[base+k]) != exp1[k]) e++;
        if (int'(samp_q[base+8+k]) != -exp1[k]) e++;
      end
      checks++;
      if (e != 0) begin failures++; $display("FAIL basic_first16 got %0d bad samples want 0", e); end
      e = stream_errors(32'hA53C00FF, base);
      checks++;
      if (e != 0) begin failures++; $display("FAIL basic_stream got %0d bad samples want 0", e); end
      checks++;
      if (rise_cyc - end_cyc < 2 || rise_cyc - end_cyc > 5) begin
        failures++; $display("FAIL basic_latency got %0d cycles after frame end want 2..5", rise_cyc - end_cyc);
      end
    end
    checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      failures++; $display("FAIL basic_no_errors got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_parity_error;
    int base, r0, fe0, e;
    bit ok;
    logic [PS-1:0] pkt;
    pkt = $urandom;
    base = samp_q.size(); r0 = run_len_q.size(); fe0 = fe_cnt;
    send_frame(8'h01, 1'b1, 1'b0);
    tick(8);
    checks++;
    if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL parity_fe_count got %0d want 1", fe_cnt - fe0); end
    send_packet(pkt);
    wait_runs(r0 + 1, 600, ok);
    e = ok ? stream_errors(pkt, base) : -1;
    checks++;
    if (e != 0) begin failures++; $display("FAIL parity_next_packet got %0d bad samples want 0", e); end
  endtask

  task automatic test_stop_error;
    int base, r0, fe0, e;
    bit ok;
    logic [PS-1:0] pkt;
    pkt = $urandom;
    base = samp_q.size(); r0 = run_len_q.size(); fe0 = fe_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    tick(60);
    checks++;
    if (fe_cnt - fe0 != 1 || samp_q.size() != base) begin
      failures++; $display("FAIL stop_err got fe=%0d samples=%0d want 1 0", fe_cnt - fe0, samp_q.size() - base);
    end
    uart_stream = 1'b0;
    tick(1);
    uart_stream = 1'b1;
    tick(60);
    checks++;
    if (fe_cnt - fe0 != 1 || samp_q.size() != base) begin
      failures++; $display("FAIL glitch got fe=%0d samples=%0d want 1 0", fe_cnt - fe0, samp_q.size() - base);
    end
    send_packet(pkt);
    wait_runs(r0 + 1, 600, ok);
    e = ok ? stream_errors(pkt, base) : -1;
    checks++;
    if (e != 0) begin failures++; $display("FAIL stop_next_packet got %0d bad samples want 0", e); end
  endtask

  task automatic test_back_to_back;
    int base, r0, ov0, e1, e3;
    bit ok;
    logic [PS-1:0] p1, p2, p3;
    p1 = $urandom; p2 = $urandom; p3 = $urandom;
    base = samp_q.size(); r0 = run_len_q.size(); ov0 = ov_cnt;
    send_packet(p1);
    send_packet(p2);
    send_packet(p3);
    wait_runs(r0 + 2, 700, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout got runs=%0d want %0d", run_len_q.size() - r0, 2); end
    checks++;
    if (ov_cnt - ov0 != 1) begin failures++; $display("FAIL b2b_overflow got %0d want 1", ov_cnt - ov0); end
    e1 = stream_errors(p1, base);
    e3 = stream_errors(p3, base + PKT_CYC);
    checks++;
    if (e1 != 0 || e3 != 0) begin
      failures++; $display("FAIL b2b_stream got bad pkt1=%0d pkt3=%0d want 0 0", e1, e3);
    end
  endtask

  task automatic test_async_reset;
    int base, r1, e;
    bit ok, seen;
    logic [PS-1:0] pa, pb;
    pa = $urandom; pb = $urandom;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    uart_stream = 1'b0;
    tick(BD);
    uart_stream = 1'b1;
    tick(BD + 2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (signal !== '0 || tx_active !== 1'b0) begin
      failures++; $display("FAIL rst_byte3 got sig=%0d act=%b want 0 0", signal, tx_active);
    end
    uart_stream = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    send_packet(pa);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_active === 1'b1 && signal !== '0) begin seen = 1'b1; break; end
      tick(1);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_send_start got act=%b want 1 with nonzero signal", tx_active); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (signal !== '0 || tx_active !== 1'b0) begin
      failures++; $display("FAIL rst_send got sig=%0d act=%b want 0 0", signal, tx_active);
    end
    tick(3);
    rst = 1'b0;
    tick(20);
    base = samp_q.size(); r1 = run_len_q.size();
    send_packet(pb);
    wait_runs(r1 + 1, 600, ok);
    e = ok ? stream_errors(pb, base) : -1;
    checks++;
    if (e != 0) begin failures++; $display("FAIL rst_fresh_packet got %0d bad samples want 0", e); end
  endtask

  task automatic test_single_bit;
    int base, r0, nm0, e;
    bit ok;
    base = samp_q.size(); r0 = run_len_q.size(); nm0 = neg_min;
    send_packet(32'h80000000);
    wait_runs(r0 + 1, 600, ok);
    e = ok ? stream_errors(32'h80000000, base) : -1;
    checks++;
    if (e != 0) begin failures++; $display("FAIL msb_stream got %0d bad samples want 0", e); end
    checks++;
    if (ok && (int'(samp_q[base+1]) != A || int'(samp_q[base+9]) != -A || int'(samp_q[base+11]) != A)) begin
      failures++;
      $display("FAIL msb_phase got s1=%0d s9=%0d s11=%0d want 127 -127 127",
               samp_q[base+1], samp_q[base+9], samp_q[base+11]);
    end
    checks++;
    if (neg_min - nm0 != 0) begin failures++; $display("FAIL msb_neg_full got %0d want 0", neg_min - nm0); end
  endtask

  task automatic test_random;
    int base, r0, e;
    bit ok;
    logic [PS-1:0] pkt;
    for (int n = 0; n < 3; n++) begin
      pkt = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
      base = samp_q.size(); r0 = run_len_q.size();
      send_packet(pkt);
      wait_runs(r0 + 1, 600, ok);
      e = ok ? stream_errors(pkt, base) : -1;
      checks++;
      if (e != 0) begin failures++; $display("FAIL random_pkt%0d got %0d bad samples want 0 (pkt %h)", n, e, pkt); end
      tick($urandom_range(0, 20));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_stop_error();
    test_back_to_back();
    test_async_reset();
    test_single_bit();
    test_random();
    checks++;
    if (idle_nz != 0) begin failures++; $display("FAIL idle_signal_zero got %0d nonzero idle samples want 0", idle_nz); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
